// File: rtl/ram_writer.sv
// Streams decimated AXI-Stream samples into a circular RAM buffer
// through a single-beat AXI write master.
`timescale 1ns/1ps

module ram_writer #(
  parameter logic [31:0] BASE_ADDR      = 32'h1E00_0000,
  parameter int          MAX_LOG_LENGTH = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] GPIO,
  input  logic        S_AXIS_tvalid,
  input  logic [31:0] S_AXIS_tdata,
  output logic        S_AXIS_tready,
  output logic [31:0] M_AXI_position_awaddr,
  output logic        M_AXI_position_awvalid,
  input  logic        M_AXI_position_awready,
  output logic [7:0]  M_AXI_position_awlen,
  output logic [2:0]  M_AXI_position_awsize,
  output logic [1:0]  M_AXI_position_awburst,
  output logic [31:0] M_AXI_position_wdata,
  output logic [3:0]  M_AXI_position_wstrb,
  output logic        M_AXI_position_wlast,
  output logic        M_AXI_position_wvalid,
  input  logic        M_AXI_position_wready,
  input  logic        M_AXI_position_bvalid,
  output logic        M_AXI_position_bready,
  output logic [31:0] position,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  log_thr;
  logic [4:0]  log_len_raw;
  logic [4:0]  log_len;
  logic        enable;
  logic        request;
  logic        running;
  logic        beat;
  logic        sel;
  logic [31:0] mask;
  logic [31:0] thr_max;
  logic [30:0] cnt_q, cnt_d;
  logic [31:0] pos_q, pos_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        aw_q, aw_d;
  logic        w_q, w_d;
  logic        ovr_q, ovr_d;
  logic        unused_gpio;

  assign enable      = GPIO[0];
  assign request     = GPIO[1];
  assign log_len_raw = GPIO[6:2];
  assign log_thr     = GPIO[11:7];
  assign unused_gpio = ^GPIO[31:12];

  assign log_len = (log_len_raw > 5'(MAX_LOG_LENGTH))
                 ? 5'(MAX_LOG_LENGTH) : log_len_raw;

  assign mask    = (32'd1 << log_len) - 32'd1;
  assign thr_max = (32'd1 << log_thr) - 32'd1;

  assign running = enable & ~request;
  assign beat    = running & S_AXIS_tvalid;
  assign sel     = beat & (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    addr_d  = addr_q;
    data_d  = data_q;
    aw_d    = aw_q;
    w_d     = w_q;
    ovr_d   = ovr_q;

    // >= rather than == so a smaller throttle applied mid-run recovers
    if (beat) begin
      if ({1'b0, cnt_q} >= thr_max) cnt_d = '0;
      else                          cnt_d = cnt_q + 31'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (sel) begin
          data_d  = S_AXIS_tdata;
          addr_d  = BASE_ADDR + ((pos_q & mask) << 2);
          aw_d    = 1'b1;
          w_d     = 1'b1;
          state_d = WRITE;
        end else if (!enable) begin
          pos_d = '0;
          cnt_d = '0;
          ovr_d = 1'b0;
        end
      end
      WRITE: begin
        aw_d = aw_q & ~M_AXI_position_awready;
        w_d  = w_q & ~M_AXI_position_wready;
        if (!aw_d && !w_d) state_d = RESP;
      end
      RESP: begin
        if (M_AXI_position_bvalid) begin
          pos_d   = (pos_q + 32'd1) & mask;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sel && state_q != IDLE) ovr_d = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pos_q   <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      aw_q    <= 1'b0;
      w_q     <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      aw_q    <= aw_d;
      w_q     <= w_d;
      ovr_q   <= ovr_d;
    end
  end

  assign S_AXIS_tready          = 1'b1;
  assign M_AXI_position_awaddr  = addr_q;
  assign M_AXI_position_awvalid = aw_q;
  assign M_AXI_position_awlen   = 8'd0;
  assign M_AXI_position_awsize  = 3'b010;
  assign M_AXI_position_awburst = 2'b01;
  assign M_AXI_position_wdata   = data_q;
  assign M_AXI_position_wstrb   = 4'hF;
  assign M_AXI_position_wlast   = 1'b1;
  assign M_AXI_position_wvalid  = w_q;
  assign M_AXI_position_bready  = 1'b1;
  assign position               = pos_q;
  assign overrun                = ovr_q;

endmodule

// File: tb/tb_ram_writer.sv
// Directed bench for ram_writer: AXI slave model, write log,
// hand-computed addresses, data, position and overrun.
`timescale 1ns/1ps

module tb_ram_writer;

  localparam logic [31:0] BASE = 32'h1E00_0000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] gpio = '0;
  logic        tvalid = 1'b0;
  logic [31:0] tdata = 32'hA000_0000;
  logic        tready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b1;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b1;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] position;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int bdelay  = 1;
  int src_mode = 0;
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];

  ram_writer dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .GPIO                   (gpio),
    .S_AXIS_tvalid          (tvalid),
    .S_AXIS_tdata           (tdata),
    .S_AXIS_tready          (tready),
    .M_AXI_position_awaddr  (awaddr),
    .M_AXI_position_awvalid (awvalid),
    .M_AXI_position_awready (awready),
    .M_AXI_position_awlen   (awlen),
    .M_AXI_position_awsize  (awsize),
    .M_AXI_position_awburst (awburst),
    .M_AXI_position_wdata   (wdata),
    .M_AXI_position_wstrb   (wstrb),
    .M_AXI_position_wlast   (wlast),
    .M_AXI_position_wvalid  (wvalid),
    .M_AXI_position_wready  (wready),
    .M_AXI_position_bvalid  (bvalid),
    .M_AXI_position_bready  (bready),
    .position               (position),
    .overrun                (overrun)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_aw(input int n);
    int t;
    t = 0;
    while (aw_log.size() < n && t < 3000) begin
      cyc();
      t++;
    end
    chk("wait_aw", 32'(aw_log.size() >= n), 32'd1);
  endtask

  task automatic wait_awvalid();
    int t;
    t = 0;
    while (awvalid !== 1'b1 && t < 3000) begin
      cyc();
      t++;
    end
    chk("wait_awvalid", 32'(awvalid), 32'd1);
  endtask

  // slave: logs handshakes, bvalid bdelay cycles after aw+w both done
  initial begin : slave
    bit aw_hs, w_hs, b_hs, rst, ad, wd;
    int bcnt;
    ad = 0;
    wd = 0;
    bcnt = 0;
    forever begin
      @(negedge aclk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid;
      rst   = !aresetn;
      if (!rst && aw_hs) aw_log.push_back(awaddr);
      if (!rst && w_hs)  w_log.push_back(wdata);
      @(posedge aclk);
      #1;
      if (rst) begin
        ad = 0;
        wd = 0;
        bcnt = 0;
        bvalid = 1'b0;
      end else begin
        if (b_hs) bvalid = 1'b0;
        if (aw_hs) ad = 1;
        if (w_hs) wd = 1;
        if (ad && wd) begin
          ad = 0;
          wd = 0;
          bcnt = bdelay;
        end
        if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) bvalid = 1'b1;
        end
      end
    end
  end

  initial begin : source
    forever begin
      cyc();
      if (tvalid) tdata = tdata + 32'd1;
      case (src_mode)
        0:       tvalid = 1'b0;
        1:       tvalid = ~tvalid;
        default: tvalid = 1'b1;
      endcase
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] pos0;
    int n0, n1, n2, n3, bad;

    repeat (5) cyc();
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_awaddr", awaddr, BASE);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_pos", position, 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("tready", 32'(tready), 32'd1);
    chk("awlen", 32'(awlen), 32'd0);
    chk("awsize", 32'(awsize), 32'd2);
    chk("awburst", 32'(awburst), 32'd1);
    chk("wstrb", 32'(wstrb), 32'hF);
    chk("wlast_bready", 32'({wlast, bready}), 32'd3);

    // len 64, every 2nd beat, beats on alternate cycles
    aresetn = 1'b1;
    gpio = 32'h99;
    src_mode = 1;
    wait_aw(66);
    repeat (4) cyc();
    chk("w0_addr", aw_log[0], BASE);
    chk("w0_data", w_log[0], 32'hA000_0000);
    chk("w1_addr", aw_log[1], BASE + 32'h4);
    chk("w1_data", w_log[1], 32'hA000_0002);
    chk("w63_addr", aw_log[63], BASE + 32'hFC);
    chk("w63_data", w_log[63], 32'hA000_007E);
    chk("w64_wrap", aw_log[64], BASE);
    chk("w64_data", w_log[64], 32'hA000_0080);
    chk("run_ovr", 32'(overrun), 32'd0);

    // freeze
    gpio = 32'h9B;
    repeat (10) cyc();
    pos0 = position;
    n0 = aw_log.size();
    chk("frz_pos", pos0, 32'(n0 % 64));
    bad = 0;
    repeat (100) begin
      cyc();
      if (position !== pos0) bad++;
    end
    chk("frz_hold", 32'(bad), 32'd0);
    chk("frz_noaw", 32'(aw_log.size()), 32'(n0));
    gpio = 32'h99;
    wait_aw(n0 + 1);
    chk("resume_addr", aw_log[n0], BASE + (pos0 << 2));

    // address channel stalled
    awready = 1'b0;
    wait_awvalid();
    repeat (3) cyc();
    chk("stall_wvalid", 32'(wvalid), 32'd0);
    chk("stall_awvalid", 32'(awvalid), 32'd1);
    n1 = aw_log.size();
    repeat (10) cyc();
    chk("stall_ovr", 32'(overrun), 32'd1);
    chk("stall_hold", 32'(awvalid), 32'd1);
    chk("stall_noaw", 32'(aw_log.size()), 32'(n1));
    awready = 1'b1;

    // disable clears, re-enable restarts at word 0
    gpio = 32'h98;
    repeat (10) cyc();
    chk("dis_pos", position, 32'd0);
    chk("dis_ovr", 32'(overrun), 32'd0);
    chk("dis_idle", 32'(awvalid), 32'd0);
    n2 = aw_log.size();
    gpio = 32'h99;
    wait_aw(n2 + 1);
    chk("reen_addr", aw_log[n2], BASE);

    // throttle 0, len 4, slow response: one write per 5 beats
    gpio = 32'h00;
    src_mode = 2;
    repeat (10) cyc();
    n3 = aw_log.size();
    bdelay = 3;
    gpio = 32'h09;
    wait_aw(n3 + 5);
    repeat (3) cyc();
    for (int i = 0; i < 5; i++)
      chk($sformatf("len4_addr%0d", i), aw_log[n3 + i],
          BASE + 32'(4 * (i % 4)));
    chk("drop_d1", w_log[n3 + 1] - w_log[n3], 32'd5);
    chk("drop_d2", w_log[n3 + 2] - w_log[n3 + 1], 32'd5);
    chk("drop_ovr", 32'(overrun), 32'd1);

    // reset while stuck in WRITE
    awready = 1'b0;
    wait_awvalid();
    aresetn = 1'b0;
    cyc();
    chk("mid_awvalid", 32'(awvalid), 32'd0);
    chk("mid_wvalid", 32'(wvalid), 32'd0);
    chk("mid_awaddr", awaddr, BASE);
    chk("mid_wdata", wdata, 32'd0);
    chk("mid_pos", position, 32'd0);
    chk("mid_ovr", 32'(overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
